// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of mem_port_arbiter.
// The slave modport is the arbiter side; the master modport is the CPU/memory side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;

   logic        m_mreq;
   logic        m_write;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;

   logic        busy;
   logic        timeout_err;

   modport slave (
      input  if_req, if_addr,
      output if_ack, if_rdata,
      input  d_req, d_write, d_size, d_addr, d_wdata,
      output d_ack, d_rdata,
      output m_mreq, m_write, m_size, m_addr, m_wdata,
      input  m_rdata, m_ready,
      output busy, timeout_err
   );

   modport master (
      output if_req, if_addr,
      input  if_ack, if_rdata,
      output d_req, d_write, d_size, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  m_mreq, m_write, m_size, m_addr, m_wdata,
      output m_rdata, m_ready,
      input  busy, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and the MEM-stage data port.
// State | meaning:  IDLE | no access, arbitrate;  GRANT_F | fetch owns memory;  GRANT_D | data owns memory
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   mem_port_arbiter_if.slave         bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_F = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      r_state;
   logic        r_last_d;
   logic [7:0]  r_wait_cnt;

   logic        r_m_mreq;
   logic        r_m_write;
   logic [1:0]  r_m_size;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_wdata;

   logic        r_if_ack;
   logic [31:0] r_if_rdata;
   logic        r_d_ack;
   logic [31:0] r_d_rdata;
   logic        r_timeout_err;

   logic        w_f_elig;
   logic        w_d_elig;
   logic        w_grant_d;
   logic        w_grant_f;
   logic        w_access_end;

   // A requester whose ack is high is still showing its old request.
   assign w_f_elig     = bus.if_req & ~r_if_ack;
   assign w_d_elig     = bus.d_req  & ~r_d_ack;
   assign w_grant_d    = w_d_elig & (~w_f_elig | ~r_last_d);
   assign w_grant_f    = w_f_elig & ~w_grant_d;
   assign w_access_end = bus.m_ready | (r_wait_cnt == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last_d      <= 1'b0;
         r_wait_cnt    <= 8'd0;
         r_m_mreq      <= 1'b0;
         r_m_write     <= 1'b0;
         r_m_size      <= 2'b00;
         r_m_addr      <= 32'd0;
         r_m_wdata     <= 32'd0;
         r_if_ack      <= 1'b0;
         r_if_rdata    <= 32'd0;
         r_d_ack       <= 1'b0;
         r_d_rdata     <= 32'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_if_ack      <= 1'b0;
         r_if_rdata    <= 32'd0;
         r_d_ack       <= 1'b0;
         r_d_rdata     <= 32'd0;
         r_timeout_err <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_state    <= GRANT_D;
                  r_last_d   <= 1'b1;
                  r_wait_cnt <= 8'd0;
                  r_m_mreq   <= 1'b1;
                  r_m_write  <= bus.d_write;
                  r_m_size   <= bus.d_size;
                  r_m_addr   <= bus.d_addr;
                  r_m_wdata  <= bus.d_wdata;
               end else if (w_grant_f) begin
                  r_state    <= GRANT_F;
                  r_last_d   <= 1'b0;
                  r_wait_cnt <= 8'd0;
                  r_m_mreq   <= 1'b1;
                  r_m_write  <= 1'b0;
                  r_m_size   <= 2'b00;
                  r_m_addr   <= bus.if_addr;
                  r_m_wdata  <= 32'd0;
               end
            end

            GRANT_F, GRANT_D: begin
               if (w_access_end) begin
                  // m_ready wins over a simultaneous timeout
                  r_state       <= IDLE;
                  r_m_mreq      <= 1'b0;
                  r_m_write     <= 1'b0;
                  r_m_size      <= 2'b00;
                  r_m_addr      <= 32'd0;
                  r_m_wdata     <= 32'd0;
                  r_timeout_err <= ~bus.m_ready;
                  if (r_state == GRANT_F) begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= bus.m_ready ? bus.m_rdata : 32'd0;
                  end else begin
                     r_d_ack    <= 1'b1;
                     r_d_rdata  <= (bus.m_ready && !r_m_write) ? bus.m_rdata : 32'd0;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.m_mreq      = r_m_mreq;
   assign bus.m_write     = r_m_write;
   assign bus.m_size      = r_m_size;
   assign bus.m_addr      = r_m_addr;
   assign bus.m_wdata     = r_m_wdata;
   assign bus.if_ack      = r_if_ack;
   assign bus.if_rdata    = r_if_rdata;
   assign bus.d_ack       = r_d_ack;
   assign bus.d_rdata     = r_d_rdata;
   assign bus.timeout_err = r_timeout_err;
   assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with TIMEOUT=15.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic inputs_idle;
      bus.if_req  = 1'b0;
      bus.if_addr = 32'd0;
      bus.d_req   = 1'b0;
      bus.d_write = 1'b0;
      bus.d_size  = 2'b00;
      bus.d_addr  = 32'd0;
      bus.d_wdata = 32'd0;
      bus.m_rdata = 32'd0;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic [135:0] obs;
      rst = 1'b1;
      inputs_idle();
      tick();
      tick();
      rst = 1'b0;
      obs = {bus.if_ack, bus.if_rdata, bus.d_ack, bus.d_rdata, bus.m_mreq, bus.m_write,
             bus.m_size, bus.m_addr, bus.m_wdata, bus.busy, bus.timeout_err};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want all zero", obs);
      end
   endtask

   task automatic test_load;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b00;
      bus.d_addr = 32'h100; bus.d_wdata = 32'd0;
      tick();
      checks++;
      if ({bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr} !== {1'b1, 1'b0, 2'b00, 32'h100}) begin
         errors++;
         $display("FAIL load_mport: got %h want %h", {bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr},
                  {1'b1, 1'b0, 2'b00, 32'h100});
      end
      checks++;
      if ({bus.busy, bus.d_ack} !== 2'b10) begin
         errors++;
         $display("FAIL load_busy_noack: got %b want 10", {bus.busy, bus.d_ack});
      end
      bus.m_ready = 1'b1; bus.m_rdata = 32'hDEADBEEF;
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata, bus.m_mreq} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
         errors++;
         $display("FAIL load_ack: got ack=%b rdata=%h mreq=%b want 1 deadbeef 0",
                  bus.d_ack, bus.d_rdata, bus.m_mreq);
      end
      bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata, bus.m_mreq, bus.busy} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load_no_regrant: got ack=%b rdata=%h mreq=%b busy=%b want 0 0 0 0",
                  bus.d_ack, bus.d_rdata, bus.m_mreq, bus.busy);
      end
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic test_contention;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h400;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b00;
      bus.d_addr = 32'h200; bus.d_wdata = 32'h55;
      tick();
      checks++;
      if ({bus.m_mreq, bus.m_addr} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL cont_data_first: got mreq=%b addr=%h want 1 00000200", bus.m_mreq, bus.m_addr);
      end
      bus.m_ready = 1'b1; bus.m_rdata = 32'h11111111;
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata, bus.if_ack, bus.m_mreq} !== {1'b1, 32'h11111111, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL cont_d_ack: got dack=%b rdata=%h iack=%b mreq=%b want 1 11111111 0 0",
                  bus.d_ack, bus.d_rdata, bus.if_ack, bus.m_mreq);
      end
      bus.m_ready = 1'b0;
      tick();
      checks++;
      if ({bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata} !==
          {1'b1, 1'b0, 2'b00, 32'h400, 32'h0}) begin
         errors++;
         $display("FAIL cont_fetch_grant: got mreq=%b wr=%b size=%b addr=%h wdata=%h want 1 0 00 00000400 0",
                  bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata);
      end
      bus.m_ready = 1'b1; bus.m_rdata = 32'h22222222;
      tick();
      checks++;
      if ({bus.if_ack, bus.if_rdata, bus.d_ack, bus.m_mreq} !== {1'b1, 32'h22222222, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL cont_if_ack: got iack=%b rdata=%h dack=%b mreq=%b want 1 22222222 0 0",
                  bus.if_ack, bus.if_rdata, bus.d_ack, bus.m_mreq);
      end
      bus.m_ready = 1'b0;
      tick();
      checks++;
      if ({bus.m_mreq, bus.m_addr} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL cont_alternate: got mreq=%b addr=%h want 1 00000200", bus.m_mreq, bus.m_addr);
      end
      bus.m_ready = 1'b1; bus.m_rdata = 32'h33333333;
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h33333333}) begin
         errors++;
         $display("FAIL cont_d_ack2: got ack=%b rdata=%h want 1 33333333", bus.d_ack, bus.d_rdata);
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b0;
      tick();
      checks++;
      if ({bus.busy, bus.m_mreq} !== 2'b00) begin
         errors++;
         $display("FAIL cont_idle: got busy/mreq=%b want 00", {bus.busy, bus.m_mreq});
      end
   endtask

   task automatic test_store_addr_hold;
      bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_size = 2'b10;
      bus.d_addr = 32'h23; bus.d_wdata = 32'hAB; bus.m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.d_ack} !==
             {1'b1, 1'b1, 2'b10, 32'h23, 32'hAB, 1'b0}) begin
            errors++;
            $display("FAIL store_hold cycle %0d: got mreq=%b wr=%b size=%b addr=%h wdata=%h ack=%b want 1 1 10 00000023 000000ab 0",
                     i, bus.m_mreq, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.d_ack);
         end
         if (i == 1) begin
            bus.d_addr = 32'h999; bus.d_wdata = 32'hCD; bus.d_size = 2'b00; bus.d_write = 1'b0;
         end
         if (i == 4) begin
            bus.m_ready = 1'b1; bus.m_rdata = 32'hFFFFFFFF;
         end
      end
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata, bus.m_mreq} !== {1'b1, 32'd0, 1'b0}) begin
         errors++;
         $display("FAIL store_ack: got ack=%b rdata=%h mreq=%b want 1 0 0", bus.d_ack, bus.d_rdata, bus.m_mreq);
      end
      bus.d_req = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
      tick();
   endtask

   task automatic test_timeout;
      bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.m_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if ({bus.m_mreq, bus.if_ack, bus.timeout_err} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_wait cycle %0d: got mreq/ack/err=%b want 100",
                     i, {bus.m_mreq, bus.if_ack, bus.timeout_err});
         end
      end
      bus.m_rdata = 32'h77777777;
      tick();
      checks++;
      if ({bus.timeout_err, bus.if_ack, bus.if_rdata, bus.busy, bus.m_mreq} !==
          {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL timeout_abort: got err=%b ack=%b rdata=%h busy=%b mreq=%b want 1 1 0 0 0",
                  bus.timeout_err, bus.if_ack, bus.if_rdata, bus.busy, bus.m_mreq);
      end
      bus.if_req = 1'b0; bus.m_rdata = 32'd0;
      tick();
      checks++;
      if ({bus.timeout_err, bus.if_ack} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_pulse: got err/ack=%b want 00", {bus.timeout_err, bus.if_ack});
      end
   endtask

   task automatic test_timeout_boundary;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b01; bus.d_addr = 32'h44;
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (bus.m_mreq !== 1'b1) begin
            errors++;
            $display("FAIL boundary_wait cycle %0d: got mreq=%b want 1", i, bus.m_mreq);
         end
         if (i == 16) begin
            bus.m_ready = 1'b1; bus.m_rdata = 32'h5A5A5A5A;
         end
      end
      tick();
      checks++;
      if ({bus.d_ack, bus.d_rdata, bus.timeout_err} !== {1'b1, 32'h5A5A5A5A, 1'b0}) begin
         errors++;
         $display("FAIL boundary_ack: got ack=%b rdata=%h err=%b want 1 5a5a5a5a 0",
                  bus.d_ack, bus.d_rdata, bus.timeout_err);
      end
      bus.d_req = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
      tick();
   endtask

   task automatic test_reset_mid_access;
      logic [135:0] obs;
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b00; bus.d_addr = 32'h300;
      bus.m_ready = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.m_mreq, bus.busy} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_pre: got mreq/busy=%b want 11", {bus.m_mreq, bus.busy});
      end
      rst = 1'b1;
      tick();
      obs = {bus.if_ack, bus.if_rdata, bus.d_ack, bus.d_rdata, bus.m_mreq, bus.m_write,
             bus.m_size, bus.m_addr, bus.m_wdata, bus.busy, bus.timeout_err};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs: got %h want all zero", obs);
      end
      rst = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h1234;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if ({bus.d_ack, bus.if_ack, bus.m_mreq, bus.timeout_err, bus.d_rdata} !== 36'd0) begin
            errors++;
            $display("FAIL rstmid_ignore cycle %0d: got dack=%b iack=%b mreq=%b err=%b rdata=%h want all 0",
                     i, bus.d_ack, bus.if_ack, bus.m_mreq, bus.timeout_err, bus.d_rdata);
         end
      end
      bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_contention();
      test_store_addr_hold();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, is the number of wait cycles without m_ready before a granted access is aborted (legal range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: if_req  in  1  fetch request; held high until if_ack is seen.
REQ-005 Port: if_addr  in  32  fetch address; always a word read.
REQ-006 Port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-007 Port: if_rdata  out  32  fetch data; valid while if_ack=1.
REQ-008 Port: d_req  in  1  data request from MEM stage (its mreq); held until d_ack.
REQ-009 Port: d_write  in  1  1=store, 0=load.
REQ-010 Port: d_size  in  2  access size: 00 WORD, 01 HALF, 10 BYTE.
REQ-011 Port: d_addr  in  32  data address.
REQ-012 Port: d_wdata  in  32  store data, already lane-converted by MEM stage.
REQ-013 Port: d_ack  out  1  one-cycle data completion pulse.
REQ-014 Port: d_rdata  out  32  raw load data, valid while d_ack=1; sign/zero extension stays in MEM stage.
REQ-015 Port: m_mreq  out  1  memory request.
REQ-016 Port: m_write  out  1  memory write enable.
REQ-017 Port: m_size  out  2  memory access size, same encoding as d_size.
REQ-018 Port: m_addr  out  32  memory address.
REQ-019 Port: m_wdata  out  32  memory write data.
REQ-020 Port: m_rdata  in  32  memory read data, valid with m_ready.
REQ-021 Port: m_ready  in  1  memory completion; may assert in the first m_mreq cycle or any later cycle.
REQ-022 Port: busy  out  1  1 whenever state is not IDLE.
REQ-023 Port: timeout_err  out  1  one-cycle pulse when an access is aborted.

Function
REQ-024 FSM states: IDLE, GRANT_F, GRANT_D; registered state, no other states.
REQ-025 IDLE, only one eligible request: grant it; both eligible: grant the requester not granted last (last_grant register, alternating).
REQ-026 A requester is ineligible in the cycle its own ack is high (prevents regrant of a completing request).
REQ-027 On grant, addr/size/write/wdata are captured into registers; m_* are driven only from these registers, so m_mreq rises the cycle after req is sampled.
REQ-028 Fetch grant: m_write=0, m_size=00, m_wdata=0, m_addr=captured if_addr.
REQ-029 Data grant: m_write/m_size/m_addr/m_wdata = captured d_write/d_size/d_addr/d_wdata.
REQ-030 In GRANT_x, m_* stay constant regardless of input changes until the access ends.
REQ-031 In GRANT_x with m_ready=1: next cycle owner ack=1, owner rdata=m_rdata sampled that edge (0 for stores), state -> IDLE, m_mreq=0.
REQ-032 Wait counter (8 bit) clears on grant and increments each GRANT_x cycle with m_ready=0; when it equals TIMEOUT: next cycle timeout_err=1, owner ack=1, owner rdata=0, state -> IDLE.
REQ-033 m_ready=1 in the same cycle the counter reaches TIMEOUT counts as normal completion; timeout_err stays 0.
REQ-034 m_ready while IDLE is ignored.
REQ-035 In IDLE and non-ack cycles: m_mreq=0, m_write=0, m_size=00, m_addr=0, m_wdata=0, both acks 0, both rdata 0.
REQ-036 Minimum access latency, req to ack: 2 cycles with m_ready in the first m_mreq cycle; back-to-back grants leave exactly one m_mreq=0 cycle between accesses.

Reset
REQ-037 rst=1 at a clock edge: state=IDLE, last_grant=fetch (data wins first contention), counter=0, all outputs 0 next cycle.
REQ-038 Reset mid-access abandons it: no ack, no timeout_err; subsequent m_ready ignored.

Verification
REQ-039 d_req only, load WORD addr 0x100, m_ready at first m_mreq cycle with m_rdata 0xDEADBEEF -> d_ack one cycle, d_rdata 0xDEADBEEF, two cycles after d_req.
REQ-040 if_req and d_req both high from reset -> data granted first, fetch next, one idle m_mreq cycle between; alternation continues while both held.
REQ-041 Store BYTE, d_addr 0x23, d_wdata 0x000000AB, m_ready after 3 wait cycles -> m_write=1, m_size=10, m_addr=0x23 stable 4 cycles; d_ack with d_rdata 0.
REQ-042 m_ready never asserted, TIMEOUT=15 -> timeout_err and if_ack pulse together after 15 wait cycles, if_rdata 0, busy drops.
REQ-043 rst asserted during GRANT_D wait -> all outputs 0 next cycle, no d_ack; later m_ready produces no ack.
REQ-044 d_addr changed mid-access -> m_addr keeps captured value until completion.
